// File: rtl/nibble_loop_sequencer_if.sv
// ALU command/control types and the request/response/loop bundle shared by the
// nibble loop sequencer and whatever sits on either side of it.
package nls_pkg;
   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_XNOR, ALU_RSHFT, ALU_PASS
   } AluCmd;

   typedef struct packed {
      AluCmd cmd;
      logic  carry_in;
      logic  b_inv;
      logic  carry_disable;
   } AluCtrl;
endpackage

interface nibble_loop_sequencer_if #(
   parameter int CNT_W = 5
);
   import nls_pkg::*;

   logic              req_valid;
   logic              req_ready;
   AluCmd             req_cmd;
   logic [31:0]       req_word1;
   logic [31:0]       req_word2;
   logic [2:0]        req_nibbles;
   logic              req_carry_in;
   logic              req_b_inv;
   logic              req_carry_disable;
   logic              req_signed_neg;
   logic              req_check_eq;

   logic              loop_perm_to_count;
   logic [2:0]        loop_nibbles_number;
   AluCtrl            loop_ctrl;
   logic [31:0]       loop_word1;
   logic [31:0]       loop_word2;
   logic [31:0]       loop_preinit;
   logic              loop_check_0xf;
   logic              loop_signed_neg;
   logic              loop_preinit_only;
   logic              loop_busy;
   logic [31:0]       loop_result;
   logic              loop_carry;

   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_result;
   logic              resp_flag;
   logic              resp_err;
   logic [CNT_W-1:0]  resp_cycles;

   // Sequencer side: drives the loop controls and both handshake replies.
   modport master (
      input  req_valid, req_cmd, req_word1, req_word2, req_nibbles, req_carry_in,
             req_b_inv, req_carry_disable, req_signed_neg, req_check_eq,
             loop_busy, loop_result, loop_carry, resp_ready,
      output req_ready, loop_perm_to_count, loop_nibbles_number, loop_ctrl,
             loop_word1, loop_word2, loop_preinit, loop_check_0xf, loop_signed_neg,
             loop_preinit_only, resp_valid, resp_result, resp_flag, resp_err, resp_cycles
   );

   modport slave (
      output req_valid, req_cmd, req_word1, req_word2, req_nibbles, req_carry_in,
             req_b_inv, req_carry_disable, req_signed_neg, req_check_eq,
             loop_busy, loop_result, loop_carry, resp_ready,
      input  req_ready, loop_perm_to_count, loop_nibbles_number, loop_ctrl,
             loop_word1, loop_word2, loop_preinit, loop_check_0xf, loop_signed_neg,
             loop_preinit_only, resp_valid, resp_result, resp_flag, resp_err, resp_cycles
   );
endinterface

// File: rtl/nibble_loop_sequencer.sv
// Accepts one ALU request, arms the nibble loop for one cycle, runs it under
// timeout supervision and holds the captured result until the response handshake.
module nibble_loop_sequencer
   import nls_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   nibble_loop_sequencer_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYCLES);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rst_sync;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_accept;
   logic              w_capture;
   logic              w_timeout;

   logic              r_req_ready;
   logic              r_perm;
   logic              r_resp_valid;
   logic [2:0]        r_loop_nib;
   AluCtrl            r_loop_ctrl;
   logic [31:0]       r_loop_word1;
   logic [31:0]       r_loop_word2;
   logic [31:0]       r_loop_preinit;
   logic              r_loop_chk;
   logic              r_loop_sneg;
   logic [31:0]       r_resp_result;
   logic              r_resp_flag;
   logic              r_resp_err;
   logic [CNT_W-1:0]  r_resp_cycles;

   // Reset release is retimed so the FSM first moves on the second edge after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 1'b0;
      else        r_rst_sync <= 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      if (r_rst_sync) begin
         case (r_state)
            S_IDLE: if (bus.req_valid && r_req_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ARM;
            end
            S_ARM:  w_state_nxt = S_RUN;
            S_RUN:  if (!bus.loop_busy) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_cnt_inc >= CNT_TMO) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_DONE;
            end
            S_DONE: if (bus.resp_ready && r_resp_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Control outputs are decoded from the next state so they are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_perm       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_req_ready  <= (w_state_nxt == S_IDLE);
         r_perm       <= (w_state_nxt == S_RUN);
         r_resp_valid <= (w_state_nxt == S_DONE);
         if (r_state == S_ARM)
            r_cnt <= '0;
         else if (r_state == S_RUN && bus.loop_busy)
            r_cnt <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_loop_nib     <= '0;
         r_loop_ctrl    <= '0;
         r_loop_word1   <= '0;
         r_loop_word2   <= '0;
         r_loop_preinit <= '0;
         r_loop_chk     <= 1'b0;
         r_loop_sneg    <= 1'b0;
         r_resp_result  <= '0;
         r_resp_flag    <= 1'b0;
         r_resp_err     <= 1'b0;
         r_resp_cycles  <= '0;
      end else begin
         if (w_accept) begin
            r_loop_nib                <= bus.req_nibbles;
            r_loop_ctrl.cmd           <= bus.req_cmd;
            r_loop_ctrl.carry_in      <= bus.req_carry_in;
            r_loop_ctrl.b_inv         <= bus.req_b_inv;
            r_loop_ctrl.carry_disable <= bus.req_carry_disable;
            r_loop_word1              <= bus.req_word1;
            r_loop_word2              <= bus.req_word2;
            r_loop_preinit            <= (bus.req_cmd == ALU_RSHFT) ? '0 : bus.req_word1;
            r_loop_chk                <= bus.req_check_eq;
            r_loop_sneg               <= bus.req_signed_neg;
         end
         if (w_capture) begin
            r_resp_result <= bus.loop_result;
            r_resp_flag   <= bus.loop_carry;
            r_resp_err    <= 1'b0;
            r_resp_cycles <= r_cnt;
         end else if (w_timeout) begin
            r_resp_result <= '0;
            r_resp_flag   <= 1'b0;
            r_resp_err    <= 1'b1;
            r_resp_cycles <= w_cnt_inc;
         end
      end
   end

   assign bus.req_ready           = r_req_ready;
   assign bus.loop_perm_to_count  = r_perm;
   assign bus.loop_nibbles_number = r_loop_nib;
   assign bus.loop_ctrl           = r_loop_ctrl;
   assign bus.loop_word1          = r_loop_word1;
   assign bus.loop_word2          = r_loop_word2;
   assign bus.loop_preinit        = r_loop_preinit;
   assign bus.loop_check_0xf      = r_loop_chk;
   assign bus.loop_signed_neg     = r_loop_sneg;
   assign bus.loop_preinit_only   = 1'b0;
   assign bus.resp_valid          = r_resp_valid;
   assign bus.resp_result         = r_resp_result;
   assign bus.resp_flag           = r_resp_flag;
   assign bus.resp_err            = r_resp_err;
   assign bus.resp_cycles         = r_resp_cycles;

endmodule

// File: tb/tb_nibble_loop_sequencer.sv
// Self-checking bench: a behavioural nibble loop answers the sequencer, and each
// response is compared with a word-level model of the requested ALU operation.
module tb_nibble_loop_sequencer;
   import nls_pkg::*;

   localparam int TMO = 16;

   typedef struct {
      AluCmd       cmd;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [2:0]  nib;
      logic        cin, binv, cdis, sneg, chk;
   } req_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_mis = 0;
   int   busy_len = 0;
   int   run_cnt = 0;

   nibble_loop_sequencer_if #(.CNT_W(5)) bus ();

   nibble_loop_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Word-level ALU: op over the low (nib+1) nibbles, preinit elsewhere; a
   // signed-negative word2 is sign-extended and the op spans all 32 bits.
   function automatic logic [32:0] alu_fn(input AluCmd cmd, input logic [31:0] a, input logic [31:0] b_in,
                                           input logic [31:0] pre, input logic [2:0] nib,
                                           input logic cin, input logic binv, input logic cdis,
                                           input logic sneg, input logic chk);
      logic [31:0] mask, span, b, r;
      logic [63:0] s;
      logic        c, c0;
      int          w;
      mask = (nib == 3'd7) ? 32'hffff_ffff : ((32'h1 << (4 * (int'(nib) + 1))) - 32'h1);
      span = sneg ? 32'hffff_ffff : mask;
      w    = sneg ? 32 : 4 * (int'(nib) + 1);
      b    = sneg ? (b_in | ~mask) : b_in;
      if (binv) b = ~b;
      c0 = cdis ? 1'b0 : cin;
      c  = 1'b0;
      s  = '0;
      case (cmd)
         ALU_ADD:   begin s = 64'(a & span) + 64'(b & span) + 64'(c0);  r = s[31:0]; c = s[w]; end
         ALU_SUB:   begin s = 64'(a & span) + 64'(~b & span) + 64'(c0); r = s[31:0]; c = s[w]; end
         ALU_AND:   r = a & b;
         ALU_OR:    r = a | b;
         ALU_XOR:   r = a ^ b;
         ALU_XNOR:  begin r = ~(a ^ b); c = chk && ((r & span) == span); end
         ALU_RSHFT: r = (a & span) >> 4;
         default:   r = b;
      endcase
      return {c, (pre & ~span) | (r & span)};
   endfunction

   function automatic req_t mk_req(input AluCmd cmd, input logic [31:0] w1, input logic [31:0] w2,
                                    input logic [2:0] nib, input logic cin, input logic sneg, input logic chk);
      req_t rq;
      rq.cmd = cmd; rq.w1 = w1; rq.w2 = w2; rq.nib = nib; rq.cin = cin;
      rq.binv = 1'b0; rq.cdis = 1'b0; rq.sneg = sneg; rq.chk = chk;
      return rq;
   endfunction

   // Nibble loop stand-in: busy for busy_len RUN edges, then presents its answer.
   initial begin
      bus.loop_busy = 1'b0;
      bus.loop_result = '0;
      bus.loop_carry = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.loop_perm_to_count) begin
            bus.loop_busy = (run_cnt < busy_len);
            run_cnt++;
            if (bus.loop_busy) begin
               bus.loop_result = $urandom;
               bus.loop_carry  = 1'($urandom);
            end else begin
               {bus.loop_carry, bus.loop_result} = alu_fn(bus.loop_ctrl.cmd, bus.loop_word1, bus.loop_word2,
                  bus.loop_preinit, bus.loop_nibbles_number, bus.loop_ctrl.carry_in, bus.loop_ctrl.b_inv,
                  bus.loop_ctrl.carry_disable, bus.loop_signed_neg, bus.loop_check_0xf);
            end
         end else begin
            run_cnt = 0;
            bus.loop_busy   = 1'($urandom);
            bus.loop_result = $urandom;
            bus.loop_carry  = 1'($urandom);
         end
      end
   end

   task automatic drive_req(input req_t rq);
      bus.req_cmd = rq.cmd; bus.req_word1 = rq.w1; bus.req_word2 = rq.w2;
      bus.req_nibbles = rq.nib; bus.req_carry_in = rq.cin; bus.req_b_inv = rq.binv;
      bus.req_carry_disable = rq.cdis; bus.req_signed_neg = rq.sneg; bus.req_check_eq = rq.chk;
   endtask

   task automatic drive_junk();
      bus.req_cmd = AluCmd'($urandom_range(0, 7)); bus.req_word1 = $urandom; bus.req_word2 = $urandom;
      bus.req_nibbles = 3'($urandom); bus.req_carry_in = 1'($urandom); bus.req_b_inv = 1'($urandom);
      bus.req_carry_disable = 1'($urandom); bus.req_signed_neg = 1'($urandom);
      bus.req_check_eq = 1'($urandom);
   endtask

   task automatic check_reset_vals();
      check_val("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check_val("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check_val("rst_perm", 64'(bus.loop_perm_to_count), 64'd0);
      check_val("rst_loop_word1", 64'(bus.loop_word1), 64'd0);
      check_val("rst_loop_ctrl", 64'(bus.loop_ctrl), 64'd0);
      check_val("rst_loop_preinit", 64'(bus.loop_preinit), 64'd0);
      check_val("rst_resp", 64'({bus.resp_result, bus.resp_flag, bus.resp_err, bus.resp_cycles}), 64'd0);
   endtask

   task automatic do_txn(input req_t rq, input int blen, input int hold,
                         input logic [1:0] lit_en, input logic [32:0] lit);
      logic [32:0] ref_v;
      logic [31:0] pre, exp_res;
      logic        exp_flag, exp_err;
      int          exp_cyc, to;
      pre   = (rq.cmd == ALU_RSHFT) ? 32'h0 : rq.w1;
      ref_v = alu_fn(rq.cmd, rq.w1, rq.w2, pre, rq.nib, rq.cin, rq.binv, rq.cdis, rq.sneg, rq.chk);
      exp_err  = (blen >= TMO);
      exp_res  = exp_err ? 32'h0 : ref_v[31:0];
      exp_flag = exp_err ? 1'b0 : ref_v[32];
      exp_cyc  = exp_err ? TMO : blen;
      busy_len = blen;
      @(negedge clk);
      to = 0;
      while (!bus.req_ready && to < 50) begin @(negedge clk); to++; end
      check_val("idle_req_ready", 64'(bus.req_ready), 64'd1);
      drive_req(rq);
      bus.req_valid = 1'b1;
      @(negedge clk);
      check_val("arm_perm", 64'(bus.loop_perm_to_count), 64'd0);
      check_val("arm_req_ready", 64'(bus.req_ready), 64'd0);
      check_val("loop_words", {bus.loop_word1, bus.loop_word2}, {rq.w1, rq.w2});
      check_val("loop_preinit", 64'(bus.loop_preinit), 64'(pre));
      check_val("loop_ctrl", 64'(bus.loop_ctrl), 64'({rq.cmd, rq.cin, rq.binv, rq.cdis}));
      check_val("loop_misc", 64'({bus.loop_nibbles_number, bus.loop_check_0xf, bus.loop_signed_neg,
                                  bus.loop_preinit_only}), 64'({rq.nib, rq.chk, rq.sneg, 1'b0}));
      drive_junk();
      @(negedge clk);
      check_val("run_perm", 64'(bus.loop_perm_to_count), 64'd1);
      to = 0;
      while (!bus.resp_valid && to < 60) begin @(negedge clk); to++; end
      check_val("resp_valid", 64'(bus.resp_valid), 64'd1);
      check_val("latency", 64'(to), 64'(exp_err ? TMO : blen + 1));
      check_val("done_perm", 64'(bus.loop_perm_to_count), 64'd0);
      check_val("resp_result", 64'(bus.resp_result), 64'(exp_res));
      check_val("resp_flag", 64'(bus.resp_flag), 64'(exp_flag));
      check_val("resp_err", 64'(bus.resp_err), 64'(exp_err));
      check_val("resp_cycles", 64'(bus.resp_cycles), 64'(exp_cyc));
      check_val("loop_word1_held", 64'(bus.loop_word1), 64'(rq.w1));
      if (lit_en[0]) check_val("lit_result", 64'(bus.resp_result), 64'(lit[31:0]));
      if (lit_en[1]) check_val("lit_flag", 64'(bus.resp_flag), 64'(lit[32]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         drive_junk();
         check_val("hold_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_flag, bus.resp_result}),
                   64'({1'b1, exp_err, exp_flag, exp_res}));
         check_val("hold_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      check_val("post_hs", 64'({bus.resp_valid, bus.req_ready}), 64'b01);
   endtask

   initial begin
      req_t rq;
      int   to;
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      req_t rq;
      int   blen;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.resp_ready = 1'b0;
      drive_junk();
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      rq = mk_req(ALU_ADD, 32'h00ff0004, 32'h4, 3'd0, 1'b0, 1'b0, 1'b0);
      do_txn(rq, 1, 0, 2'b11, {1'b0, 32'h00ff0008});
      rq = mk_req(ALU_SUB, 32'h00001000, 32'h00000500, 3'd7, 1'b1, 1'b0, 1'b0);
      do_txn(rq, 8, 0, 2'b01, {1'b0, 32'h00000b00});
      rq = mk_req(ALU_XNOR, 32'h12341234, 32'h12341234, 3'd7, 1'b0, 1'b0, 1'b1);
      do_txn(rq, 8, 1, 2'b10, {1'b1, 32'h0});
      rq = mk_req(ALU_XNOR, 32'h22341234, 32'h12341234, 3'd7, 1'b0, 1'b0, 1'b1);
      do_txn(rq, 8, 0, 2'b10, {1'b0, 32'h0});
      rq = mk_req(ALU_ADD, 32'h0, 32'h800, 3'd2, 1'b0, 1'b1, 1'b0);
      do_txn(rq, 3, 0, 2'b01, {1'b0, 32'hfffff800});
      rq = mk_req(ALU_ADD, 32'h11111111, 32'h1, 3'd7, 1'b0, 1'b0, 1'b0);
      do_txn(rq, 100, 2, 2'b11, {1'b0, 32'h0});
      rq = mk_req(ALU_RSHFT, 32'habcd1234, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0);
      do_txn(rq, 15, 5, 2'b00, 33'h0);
      rq = mk_req(ALU_OR, 32'hf0f0f0f0, 32'h0f0f0f0f, 3'd5, 1'b1, 1'b0, 1'b0);
      do_txn(rq, 0, 0, 2'b00, 33'h0);

      // Abort in the middle of RUN, then confirm the next request still completes.
      busy_len = 10;
      @(negedge clk);
      drive_req(mk_req(ALU_ADD, 32'h5, 32'h6, 3'd7, 1'b0, 1'b0, 1'b0));
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_val("pre_abort_perm", 64'(bus.loop_perm_to_count), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_val("no_resp_after_abort", 64'({bus.resp_valid, bus.req_ready}), 64'b01);
      rq = mk_req(ALU_ADD, 32'h00ff0004, 32'h4, 3'd0, 1'b0, 1'b0, 1'b0);
      do_txn(rq, 1, 0, 2'b01, {1'b0, 32'h00ff0008});

      for (int k = 0; k < 30; k++) begin
         rq.cmd  = AluCmd'($urandom_range(0, 7));
         rq.w1   = $urandom; rq.w2 = $urandom;
         rq.nib  = 3'($urandom);
         rq.cin  = 1'($urandom); rq.binv = 1'($urandom); rq.cdis = 1'($urandom);
         rq.sneg = 1'($urandom); rq.chk = 1'($urandom);
         blen    = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 30) : $urandom_range(0, 15);
         do_txn(rq, blen, $urandom_range(0, 3), 2'b00, 33'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
